// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int OS       = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;
  localparam int DATA_W   = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Consumer-side signal bundle of the oversampling UART receiver.
interface uart_rx_os16_if;
  import uart_pkg::*;

  logic              rx;
  logic              rdy_clr;
  logic [DATA_W-1:0] dout;
  logic              rdy;
  logic              ferr;
  logic              overrun;
  logic              busy;

  modport master (
    output rx, rdy_clr,
    input  dout, rdy, ferr, overrun, busy
  );

  modport slave (
    input  rx, rdy_clr,
    output dout, rdy, ferr, overrun, busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// One-cycle tick every DIV clocks; restart re-aligns the phase to the caller's event.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and sticky status flags.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input logic           clk,
  input logic           rst,
  uart_rx_os16_if.slave bus
);

  localparam int DIV = CLK_FREQ / (BAUD * OS);

  localparam logic [3:0] SC_A   = 4'(SAMPLE_A);
  localparam logic [3:0] SC_B   = 4'(SAMPLE_B);
  localparam logic [3:0] SC_MID = 4'(SAMPLE_C);
  localparam logic [3:0] SC_END = 4'(OS - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  uart_state_t       state;
  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  logic              armed;
  logic [3:0]        sc;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              samp_a;
  logic              samp_b;
  logic [DATA_W-1:0] dout_r;
  logic              rdy_r;
  logic              ferr_r;
  logic              overrun_r;
  logic              busy_r;
  logic              tick;
  logic              start_edge;
  logic              bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A start is only accepted once the line has been seen idle, which keeps a held-low break to one byte.
  assign start_edge = (state == IDLE) && armed && rx_prev && !rx_s;
  assign bit_val    = majority3(samp_a, samp_b, rx_s);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      sc        <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      dout_r    <= '0;
      rdy_r     <= 1'b0;
      ferr_r    <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (bus.rdy_clr) begin
        rdy_r     <= 1'b0;
        ferr_r    <= 1'b0;
        overrun_r <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_edge) begin
            state  <= START;
            sc     <= '0;
            busy_r <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == SC_A) samp_a <= rx_s;
            if (sc == SC_B) samp_b <= rx_s;
            case (state)
              START: begin
                if (sc == SC_MID && bit_val) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
                end else if (sc == SC_END) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end
              end
              DATA: begin
                if (sc == SC_MID) shreg <= {bit_val, shreg[DATA_W-1:1]};
                if (sc == SC_END) begin
                  if (bit_cnt == LAST_BIT) state <= STOP;
                  else bit_cnt <= bit_cnt + 3'd1;
                end
              end
              STOP: begin
                // Leave mid stop bit so the next start edge is never missed.
                if (sc == SC_MID) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
                  if (!bit_val) armed <= 1'b0;
                  if (!rdy_r || bus.rdy_clr) begin
                    dout_r    <= shreg;
                    rdy_r     <= 1'b1;
                    ferr_r    <= !bit_val;
                    overrun_r <= bus.rdy_clr ? 1'b0 : overrun_r;
                  end else begin
                    overrun_r <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.dout    = dout_r;
  assign bus.rdy     = rdy_r;
  assign bus.ferr    = ferr_r;
  assign bus.overrun = overrun_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: frames are driven serially, expected bytes queued and matched on arrival.
module tb_uart_rx_os16;

  localparam int BIT_CLKS = 160;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  localparam int GLITCH_N = 250;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rcv_count = 0;
  exp_t exp_q[$];
  logic [7:0] dout_q = 8'h00;
  logic       rdy_q = 1'b0;

  uart_rx_os16_if bus ();

  uart_rx_os16 #(
    .CLK_FREQ (16_000_000),
    .BAUD     (100_000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One 8N1 frame; optional mid-bit glitch, rdy_clr pulse at a given clock, or reset abort.
  task automatic applyStimulus(input logic [7:0] data, input logic stop, input bit glitch,
                               input int clr_at, input int rst_at);
    logic v;
    int   b;
    for (int n = 0; n < FRAME_CLKS; n++) begin
      @(negedge clk);
      b = n / BIT_CLKS;
      if (b == 0) v = 1'b0;
      else if (b == 9) v = stop;
      else v = data[b-1];
      if (glitch && n == GLITCH_N) v = 1'b0;
      bus.rx = v;
      bus.rdy_clr = (n == clr_at);
      if (n == rst_at) begin
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.rdy_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
  endtask

  task automatic clearPulse();
    @(negedge clk);
    bus.rdy_clr = 1'b1;
    @(negedge clk);
    bus.rdy_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.rdy && (!rdy_q || bus.dout != dout_q)) begin
        rcv_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_byte", 32'(bus.dout), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_dout", 32'(bus.dout), 32'(e.data));
          checkOutput("sb_ferr", 32'(bus.ferr), 32'(e.ferr));
        end
      end
      dout_q = bus.dout;
      rdy_q  = bus.rdy;
    end
  end

  initial begin : main
    int rc0;
    bus.rx = 1'b1;
    bus.rdy_clr = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_dout", 32'(bus.dout), 32'h00);
    checkOutput("reset_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("reset_ferr", 32'(bus.ferr), 32'd0);
    checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    repeat (50) @(negedge clk);

    $display("[TB] basic byte");
    exp_q.push_back('{data: 8'h41, ferr: 1'b0});
    applyStimulus(8'h41, 1'b1, 1'b0, -1, -1);
    waitDrain("basic_drain", 200);
    checkOutput("basic_rdy", 32'(bus.rdy), 32'd1);
    checkOutput("basic_dout", 32'(bus.dout), 32'h41);
    checkOutput("basic_ferr", 32'(bus.ferr), 32'd0);
    checkOutput("basic_busy", 32'(bus.busy), 32'd0);
    clearPulse();
    checkOutput("basic_clr_rdy", 32'(bus.rdy), 32'd0);

    $display("[TB] back-to-back with glitch");
    exp_q.push_back('{data: 8'h55, ferr: 1'b0});
    exp_q.push_back('{data: 8'hA3, ferr: 1'b0});
    applyStimulus(8'h55, 1'b1, 1'b1, -1, -1);
    applyStimulus(8'hA3, 1'b1, 1'b1, 0, -1);
    waitDrain("b2b_drain", 200);
    checkOutput("b2b_dout", 32'(bus.dout), 32'hA3);
    checkOutput("b2b_overrun", 32'(bus.overrun), 32'd0);
    clearPulse();

    $display("[TB] false start");
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("false_busy_high", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("false_busy_low", 32'(bus.busy), 32'd0);
    checkOutput("false_rdy", 32'(bus.rdy), 32'd0);
    exp_q.push_back('{data: 8'h3C, ferr: 1'b0});
    applyStimulus(8'h3C, 1'b1, 1'b0, -1, -1);
    waitDrain("false_drain", 200);
    checkOutput("false_next_dout", 32'(bus.dout), 32'h3C);
    clearPulse();

    $display("[TB] bad stop and break");
    exp_q.push_back('{data: 8'h81, ferr: 1'b1});
    applyStimulus(8'h81, 1'b0, 1'b0, -1, -1);
    bus.rx = 1'b1;
    repeat (100) @(negedge clk);
    waitDrain("badstop_drain", 200);
    checkOutput("badstop_dout", 32'(bus.dout), 32'h81);
    checkOutput("badstop_ferr", 32'(bus.ferr), 32'd1);
    clearPulse();
    checkOutput("clr_ferr", 32'(bus.ferr), 32'd0);
    rc0 = rcv_count;
    exp_q.push_back('{data: 8'h00, ferr: 1'b1});
    bus.rx = 1'b0;
    repeat (3000) @(negedge clk);
    checkOutput("break_count", 32'(rcv_count - rc0), 32'd1);
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    waitDrain("break_drain", 10);
    checkOutput("break_dout", 32'(bus.dout), 32'h00);
    checkOutput("break_ferr", 32'(bus.ferr), 32'd1);
    clearPulse();

    $display("[TB] overrun");
    exp_q.push_back('{data: 8'h12, ferr: 1'b0});
    applyStimulus(8'h12, 1'b1, 1'b0, -1, -1);
    applyStimulus(8'h34, 1'b1, 1'b0, -1, -1);
    repeat (20) @(negedge clk);
    waitDrain("ovr_drain", 10);
    checkOutput("ovr_dout", 32'(bus.dout), 32'h12);
    checkOutput("ovr_flag", 32'(bus.overrun), 32'd1);
    checkOutput("ovr_rdy", 32'(bus.rdy), 32'd1);
    exp_q.push_back('{data: 8'h56, ferr: 1'b0});
    applyStimulus(8'h56, 1'b1, 1'b0, 1542, -1);
    repeat (20) @(negedge clk);
    waitDrain("ovr_clr_drain", 10);
    checkOutput("ovr_clr_dout", 32'(bus.dout), 32'h56);
    checkOutput("ovr_clr_rdy", 32'(bus.rdy), 32'd1);
    checkOutput("ovr_clr_flag", 32'(bus.overrun), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3, 1'b1, 1'b0, -1, 5 * BIT_CLKS + 80);
    @(negedge clk);
    checkOutput("midrst_dout", 32'(bus.dout), 32'h00);
    checkOutput("midrst_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("midrst_ferr", 32'(bus.ferr), 32'd0);
    checkOutput("midrst_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (200) @(negedge clk);
    exp_q.push_back('{data: 8'h7E, ferr: 1'b0});
    applyStimulus(8'h7E, 1'b1, 1'b0, -1, -1);
    waitDrain("midrst_drain", 200);
    checkOutput("midrst_next_dout", 32'(bus.dout), 32'h7E);
    checkOutput("midrst_next_rdy", 32'(bus.rdy), 32'd1);

    repeat (50) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Oversampling UART receiver: the receive end of the team's 8N1 serial link, complementing the transmit path driven by `wr_en`/`din`/`busy`. It samples the asynchronous `rx` line at 16x baud and majority-votes each bit. It presents each received byte on `dout` with a sticky `rdy` flag, cleared by the consumer through `rdy_clr`. It also reports framing errors and overruns, and drops into any design in place of a bare receiver.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DIV` (localparam): `CLK_FREQ/(BAUD*16)`, truncated. Must be ≥1; with the defaults it is 27.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `rdy_clr` input 1: one-cycle pulse that clears `rdy`, `ferr` and `overrun`.
- `dout` output 8: last accepted byte.
- `rdy` output 1: a byte is waiting in `dout`; sticky.
- `ferr` output 1: the byte in `dout` had stop bit = 0.
- `overrun` output 1: a byte completed while `rdy` = 1 and was dropped; sticky.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All logic uses `rx_s`.
- **Sample tick:** pulses one cycle every `DIV` clocks. The counter restarts when a start edge is detected, so sampling is phase-aligned to the frame.
- **Sample counter:** `sc` counts 0..15 per bit.
  - Samples are taken at `sc` = 7, 8 and 9.
  - The bit value is the majority of those three, resolved on the tick where `sc` = 9.
  - The bit period ends on the tick where `sc` = 15.
- **FSM:** IDLE → START → DATA → STOP → IDLE.
  - **IDLE:** `armed` sets when `rx_s` = 1. A falling edge on `rx_s` while armed → START, with `sc` = 0 and the tick counter restarted.
  - **START:** at `sc` = 9, majority = 1 means a false start → IDLE (no flags). Otherwise wait until `sc` = 15 → DATA.
  - **DATA:** 8 bits, LSB first, shifted into `shreg` at `sc` = 9 of each bit. After the 8th bit's `sc` = 15 → STOP.
  - **STOP:** at `sc` = 9 the byte completes → IDLE immediately, without waiting out the rest of the stop bit, so the receiver can resync on the next start edge.
- **Byte completion**, with `rdy` = 0 or `rdy_clr` = 1 in the same cycle:
  - `dout` ← `shreg`, `rdy` ← 1.
  - `ferr` ← NOT(stop majority).
  - `overrun` keeps its value, or goes to 0 if `rdy_clr` is high.
- **Byte completion** with `rdy` = 1 and `rdy_clr` = 0: the byte is dropped. `dout` and `ferr` are unchanged and `overrun` ← 1.
- **Break / line held low:** on a frame with `ferr`, `armed` clears. No new start is accepted until `rx_s` has been sampled high at least once, so a held-low line produces exactly one `ferr` byte (0x00).
- **`rdy_clr` with no completion:** clears `rdy`, `ferr` and `overrun` on the next edge.

## Timing
- **Reset values:** `dout` = 0x00, `rdy` = 0, `ferr` = 0, `overrun` = 0, `busy` = 0, FSM = IDLE, `armed` = 0, sync flops = 1. Reset asserted mid-frame aborts the frame, with no partial byte and no flags.
- **`rx` to `rx_s`:** 2 clocks.
- **`busy`:** rises the clock after the start edge is seen on `rx_s`. Falls in the same cycle that `rdy` rises, or on a false start.
- **Completion latency:** `rdy`, `dout` and `ferr` update on the clock edge after the stop-bit `sc` = 9 tick. From the `rx` falling edge this is about 2 + (9·16 + 10)·`DIV` clocks: 1542 clocks at `DIV` = 10.
- **Hold:** `rdy` stays high until a `rdy_clr` pulse. Flags never self-clear.
- **Phase tolerance:** the mid-bit sampling tolerates ±6/16 bit of accumulated baud mismatch.

## Structure
- **Package `uart_pkg`:** FSM state enum (IDLE, START, DATA, STOP), `OS` = 16, sample points 7/8/9, and the data width of 8. Shared with the transmitter.
- **Sub-module `uart_baud_tick`:** parameterized by `DIV`, with a synchronous restart input and a one-cycle `tick` output. Reusable by the transmitter with `DIV`·16.
- **Top level:** synchronizer, FSM, majority vote, shift register and flag logic all live in `uart_rx_os16`.

## Test plan
All tests use `CLK_FREQ` = 16_000_000 and `BAUD` = 100_000, so `DIV` = 10 and one bit = 160 clocks.
- **Basic byte:** drive 0x41 8N1 → `rdy` = 1, `dout` = 0x41, `ferr` = 0, `busy` low. Then pulse `rdy_clr` → `rdy` = 0.
- **Back-to-back with glitch:** send 0x55 then 0xA3 with no idle gap, and a 1-clock low glitch mid-bit on each → both received correctly. Clear between the bytes.
- **False start:** drive a 40-clock low pulse → no `rdy`, `busy` back to 0, and a following 0x3C is received correctly.
- **Bad stop / break:** send 0x81 with stop = 0 → `dout` = 0x81, `ferr` = 1. Then hold `rx` low for 3000 clocks → exactly one extra byte 0x00 with `ferr`, and no further bytes until `rx` goes high.
- **Overrun:** send 0x12 then 0x34 without clearing → `dout` = 0x12, `overrun` = 1. Then `rdy_clr` coincident with a 0x56 completion → `dout` = 0x56, `rdy` = 1, `overrun` = 0.
- **Reset mid-frame:** assert `rst` during bit 4 of a frame → all outputs reset. The next 0x7E after `rx` idles high is received correctly.
